// File: rtl/pause_arbiter.sv
// Frame-aligned halt arbiter: merges user pause, OSD pause and hiscore RAM requests
// into one core halt taken at vblank, grants RAM once stopped, and times screen dimming.
module pause_arbiter #(
  parameter logic [31:0] DIM_CYCLES = 32'd480000000,
  parameter logic [20:0] DRAIN_MAX  = 21'd1000000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       vblank,
  input  logic       btn_pause,
  input  logic       osd_open,
  input  logic       osd_pause_en,
  input  logic       hs_req,
  output logic       core_pause,
  output logic       hs_grant,
  output logic       dim_video,
  output logic [1:0] pause_state
);

  // state  | meaning
  // RUN    | core running, no stop source
  // DRAIN  | stop requested, waiting for vblank rise or timeout
  // PAUSED | core halted
  // HS     | core halted, hiscore engine owns RAM
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, PAUSED = 2'd2, HS = 2'd3} state_t;

  logic rst_meta_q, rst_sync_q, rst_n;

  // Assert asynchronously, release after two clk_sys edges.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end
  assign rst_n = rst_sync_q;

  state_t      state_q, state_d;
  logic        user_tog_q, user_tog_d;
  logic        btn_dly_q, btn_dly_d;
  logic        vblank_dly_q, vblank_dly_d;
  logic [20:0] drain_cnt_q, drain_cnt_d;
  logic [31:0] dim_cnt_q, dim_cnt_d;
  logic        dim_video_q, dim_video_d;
  logic        btn_rise, vbl_rise, src, halted;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      user_tog_q   <= 1'b0;
      btn_dly_q    <= 1'b0;
      vblank_dly_q <= 1'b0;
      drain_cnt_q  <= '0;
      dim_cnt_q    <= '0;
      dim_video_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      user_tog_q   <= user_tog_d;
      btn_dly_q    <= btn_dly_d;
      vblank_dly_q <= vblank_dly_d;
      drain_cnt_q  <= drain_cnt_d;
      dim_cnt_q    <= dim_cnt_d;
      dim_video_q  <= dim_video_d;
    end
  end

  always_comb begin
    btn_rise     = btn_pause & ~btn_dly_q;
    vbl_rise     = vblank & ~vblank_dly_q;
    btn_dly_d    = btn_pause;
    vblank_dly_d = vblank;
    user_tog_d   = user_tog_q ^ btn_rise;
    src          = user_tog_q | (osd_open & osd_pause_en) | hs_req;
    halted       = (state_q == PAUSED) || (state_q == HS);

    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (src) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        // Losing the source wins over a coincident vblank edge.
        if (!src) state_d = RUN;
        else if (vbl_rise || (drain_cnt_q == DRAIN_MAX - 21'd1)) state_d = PAUSED;
        else drain_cnt_d = drain_cnt_q + 21'd1;
      end
      PAUSED: begin
        if (hs_req) state_d = HS;
        else if (!src) state_d = RUN;
      end
      HS: begin
        if (!hs_req) state_d = PAUSED;
      end
      default: state_d = RUN;
    endcase

    if (!halted) dim_cnt_d = '0;
    else if (dim_cnt_q == DIM_CYCLES) dim_cnt_d = dim_cnt_q;
    else dim_cnt_d = dim_cnt_q + 32'd1;
    dim_video_d = halted && (dim_cnt_q == DIM_CYCLES);
  end

  always_comb begin
    core_pause  = (state_q == PAUSED) || (state_q == HS);
    hs_grant    = (state_q == HS);
    pause_state = state_q;
    dim_video   = dim_video_q;
  end

endmodule

// File: tb/tb_pause_arbiter.sv
// Directed bench for pause_arbiter with DIM_CYCLES=100, DRAIN_MAX=50; expected
// values are hand-derived from the state machine and counter rules.
module tb_pause_arbiter;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       vblank = 1'b0, btn_pause = 1'b0, osd_open = 1'b0;
  logic       osd_pause_en = 1'b0, hs_req = 1'b0;
  logic       core_pause, hs_grant, dim_video;
  logic [1:0] pause_state;
  logic       prev_cp = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  pause_arbiter #(.DIM_CYCLES(32'd100), .DRAIN_MAX(21'd50)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank), .btn_pause(btn_pause),
    .osd_open(osd_open), .osd_pause_en(osd_pause_en), .hs_req(hs_req),
    .core_pause(core_pause), .hs_grant(hs_grant), .dim_video(dim_video),
    .pause_state(pause_state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; a grant must always follow a cycle of core_pause.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (hs_grant) chk("grant_order", {31'd0, prev_cp}, 32'd1);
    prev_cp = core_pause;
  endtask

  task automatic press();
    btn_pause = 1'b1;
    tick();
    btn_pause = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_state", {30'd0, pause_state}, 32'd0);
    chk("rst_core_pause", {31'd0, core_pause}, 32'd0);
    chk("rst_hs_grant", {31'd0, hs_grant}, 32'd0);
    chk("rst_dim", {31'd0, dim_video}, 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_state", {30'd0, pause_state}, 32'd0);

    // User pause aligned to vblank, then unpause.
    press();
    chk("u_tog_state", {30'd0, pause_state}, 32'd0);
    tick();
    chk("u_drain", {30'd0, pause_state}, 32'd1);
    repeat (5) tick();
    chk("u_drain_hold", {30'd0, pause_state}, 32'd1);
    chk("u_drain_cp", {31'd0, core_pause}, 32'd0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("u_paused", {30'd0, pause_state}, 32'd2);
    chk("u_cp", {31'd0, core_pause}, 32'd1);
    press();
    chk("u_unpress_state", {30'd0, pause_state}, 32'd2);
    tick();
    chk("u_run", {30'd0, pause_state}, 32'd0);
    chk("u_run_cp", {31'd0, core_pause}, 32'd0);

    // OSD pause with vblank stuck low: timeout after exactly 50 DRAIN cycles.
    osd_open = 1'b1;
    osd_pause_en = 1'b1;
    tick();
    chk("osd_drain", {30'd0, pause_state}, 32'd1);
    repeat (49) tick();
    chk("osd_drain_49", {30'd0, pause_state}, 32'd1);
    tick();
    chk("osd_timeout", {30'd0, pause_state}, 32'd2);
    chk("osd_cp", {31'd0, core_pause}, 32'd1);
    osd_open = 1'b0;
    tick();
    chk("osd_close_run", {30'd0, pause_state}, 32'd0);
    osd_open = 1'b1;
    osd_pause_en = 1'b0;
    repeat (5) tick();
    chk("osd_disabled", {30'd0, pause_state}, 32'd0);
    osd_open = 1'b0;

    // Hiscore request from RUN.
    hs_req = 1'b1;
    tick();
    chk("hs_drain", {30'd0, pause_state}, 32'd1);
    chk("hs_drain_grant", {31'd0, hs_grant}, 32'd0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("hs_paused", {30'd0, pause_state}, 32'd2);
    chk("hs_paused_grant", {31'd0, hs_grant}, 32'd0);
    tick();
    chk("hs_grant", {31'd0, hs_grant}, 32'd1);
    chk("hs_state", {30'd0, pause_state}, 32'd3);
    hs_req = 1'b0;
    tick();
    chk("hs_release_grant", {31'd0, hs_grant}, 32'd0);
    chk("hs_release_cp", {31'd0, core_pause}, 32'd1);
    tick();
    chk("hs_release_run", {31'd0, core_pause}, 32'd0);

    // Long user pause: dim after 101 cycles in PAUSED, held, cleared on exit.
    press();
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("dim_paused", {30'd0, pause_state}, 32'd2);
    repeat (100) tick();
    chk("dim_before", {31'd0, dim_video}, 32'd0);
    tick();
    chk("dim_on", {31'd0, dim_video}, 32'd1);
    for (int i = 0; i < 49; i++) begin
      tick();
      chk("dim_hold", {31'd0, dim_video}, 32'd1);
    end
    press();
    tick();
    chk("dim_exit_run", {30'd0, pause_state}, 32'd0);
    tick();
    chk("dim_off", {31'd0, dim_video}, 32'd0);

    // Cancel in DRAIN: vblank rises on the cycle the toggle lands.
    press();
    tick();
    chk("cx_drain", {30'd0, pause_state}, 32'd1);
    repeat (3) tick();
    btn_pause = 1'b1;
    tick();
    chk("cx_tog_cp", {31'd0, core_pause}, 32'd0);
    btn_pause = 1'b0;
    vblank = 1'b1;
    tick();
    chk("cx_run", {30'd0, pause_state}, 32'd0);
    chk("cx_cp", {31'd0, core_pause}, 32'd0);
    vblank = 1'b0;
    repeat (3) begin
      tick();
      chk("cx_stay_cp", {31'd0, core_pause}, 32'd0);
    end

    // Button edge inside HS, then reset while granted.
    hs_req = 1'b1;
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    chk("rh_grant", {31'd0, hs_grant}, 32'd1);
    press();
    tick();
    chk("rh_btn_hs", {30'd0, pause_state}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("rh_grant_clr", {31'd0, hs_grant}, 32'd0);
    chk("rh_cp_clr", {31'd0, core_pause}, 32'd0);
    chk("rh_state_clr", {30'd0, pause_state}, 32'd0);
    hs_req = 1'b0;
    prev_cp = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("rh_after", {30'd0, pause_state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
